alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered WIDTH-bit ALU. Next generation of the team's 1-bit ALU slice.
- Performs logic, add/sub and signed compares in one cycle.
- Adds a start/busy/done handshake and an optional iterative shift-add multiplier.
- Sits between the ID/EX pipeline register and the EX/MEM stage. The EX stage stalls on busy_o.

Parameters:
- WIDTH, 32, datapath width in bits (≥4). The multiply step counter is $clog2(WIDTH)+1 bits wide.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  operation request; sampled only in IDLE.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1101 NAND, 0111 CMP, 1000 MUL (optional). Any other code is undefined.
- bonus_i  input  3  CMP select: 0 lt, 1 gt, 2 le, 3 ge, 4 ne, 6 eq, 5/7 constant 0.
- busy_o  output  1  multi-cycle operation in progress.
- done_o  output  1  one-cycle pulse: result_o and flags updated this cycle.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  carry out of the WIDTH-bit adder (ADD/SUB only).
- overflow_o  output  1  signed overflow (ADD/SUB); high half non-zero (MUL).

Behaviour:
- Reset (rst_i high at a clock edge):
  - FSM goes to IDLE.
  - result_o, zero_o, cout_o, overflow_o, busy_o and done_o all go to 0.
  - Any in-flight MUL is discarded with no done_o pulse. zero_o reads 0 while in reset, then follows result_o.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - start_i low: stay in IDLE, outputs hold.
  - start_i high with a single-cycle op: result and flags are computed from the sampled inputs and registered at that edge. FSM goes to DONE, so done_o is high in the next cycle (latency 1).
- DONE:
  - done_o = 1 for exactly one cycle, then FSM returns to IDLE.
  - start_i is ignored in DONE. Back-to-back issue therefore needs one gap cycle (throughput: one op per 2 cycles).
- Adder:
  - SUB computes A + ~B + 1.
  - cout_o is the adder carry out of bit WIDTH-1.
  - overflow_o = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the post-invert operand.
- CMP:
  - Uses the SUB datapath.
  - less = sum[msb] ^ overflow; equal = (sum == 0).
  - result_o = zero-extended 1-bit predicate selected by bonus_i.
  - cout_o = 0 and overflow_o = 0.
- Logic ops (AND/OR/NOR/NAND): cout_o = 0, overflow_o = 0.
- Undefined ctrl_i: result_o = 0, all flags 0, and done_o still pulses after 1 cycle.
- MUL (only with the macro):
  - On the start edge: latch both operands, clear the accumulator, count = 0, busy_o = 1.
  - Each later edge: if multiplier bit 0 is set, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and increment count.
  - The accumulator is 2·WIDTH bits, unsigned.
  - After WIDTH steps, at start edge + WIDTH:
    - result_o = accumulator[WIDTH-1:0];
    - overflow_o = |accumulator[2W-1:W];
    - cout_o = 0;
    - busy_o = 0;
    - FSM goes to DONE.
  - busy_o is high for exactly WIDTH cycles.
- start_i while busy_o or done_o is high is ignored, not queued. Operand changes during MUL have no effect.
- Registered outputs hold their values until the next done_o.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL state, accumulator, counter and opcode 1000 are present as specified above.
- Undefined: no multiplier logic. Opcode 1000 is treated as undefined (1-cycle, result 0, flags 0). busy_o is tied to 0.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, overflow_o 1, cout_o 0, zero_o 0; done_o high exactly 1 cycle after the start edge.
- SUB 5 - 5 -> result_o 0, zero_o 1, cout_o 1, overflow_o 0. Then CMP 0xFFFFFFFF vs 1:
  - bonus 0 -> 1;
  - bonus 3 -> 0;
  - bonus 6 -> 0;
  - bonus 4 -> 1.
- CMP 0x80000000 vs 0x00000001, bonus 0 -> result_o 1 (overflow-corrected less). Same operands with bonus 1 -> 0.
- MUL (macro on) 0x00010000 × 0x00010000 -> busy_o high 32 cycles, result_o 0, overflow_o 1. A start_i pulse at cycle 5 of the MUL changes nothing.
- MUL 0x0000FFFF × 0x00000003 -> result_o 0x0002FFFD, overflow_o 0. A second MUL started in the DONE cycle is ignored; one issued one cycle later is accepted.
- rst_i asserted at step 10 of a MUL -> next cycle busy_o 0, result_o 0, no done_o pulse. ctrl_i 1010 -> result_o 0, flags 0, done_o after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a start/busy/done handshake.
//   Single-cycle ops: AND, OR, ADD, SUB, NOR, NAND, CMP (signed compares).
//   Optional iterative shift-add multiplier, enabled by the macro ALU_SEQ_MUL_EN.
//   With the macro undefined, opcode 1000 behaves like any undefined opcode.
//
// Ports:
//   clk_i, rst_i        rising-edge clock, synchronous active-high reset
//   start_i             op request, sampled only in IDLE
//   src1_i, src2_i      operands A, B
//   ctrl_i              opcode
//   bonus_i             CMP predicate select
//   busy_o              multiply in progress (WIDTH cycles)
//   done_o              one-cycle pulse, result/flags were just updated
//   result_o            registered result
//   zero_o              result_o == 0 (forced low during reset)
//   cout_o, overflow_o  adder carry / signed overflow; MUL high-half non-zero

// One bit of the datapath: logic terms plus a full adder on the
// (optionally inverted) B operand.
module alu_seq_slice (
  input  logic a,
  input  logic b,
  input  logic inv,
  input  logic ci,
  output logic bx,
  output logic s,
  output logic co,
  output logic y_and,
  output logic y_or
);
  assign bx    = b ^ inv;
  assign s     = a ^ bx ^ ci;
  assign co    = (a & bx) | (ci & (a ^ bx));
  assign y_and = a & b;
  assign y_or  = a | b;
endmodule

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  input  logic [2:0]       bonus_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_CMP  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state, state_nxt;

  // ---------------------------------------------------------------
  // Bit-slice datapath
  // ---------------------------------------------------------------
  logic             sub_op;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum, b_eff, l_and, l_or;

  // CMP reuses the subtractor
  assign sub_op   = (ctrl_i == OP_SUB) || (ctrl_i == OP_CMP);
  assign carry[0] = sub_op;

  for (genvar g = 0; g < WIDTH; g++) begin : g_slice
    alu_seq_slice u_slice (
      .a     (src1_i[g]),
      .b     (src2_i[g]),
      .inv   (sub_op),
      .ci    (carry[g]),
      .bx    (b_eff[g]),
      .s     (sum[g]),
      .co    (carry[g+1]),
      .y_and (l_and[g]),
      .y_or  (l_or[g])
    );
  end

  logic add_ovf, less, equal, cmp_bit;

  assign add_ovf = (src1_i[MSB] == b_eff[MSB]) && (sum[MSB] != src1_i[MSB]);
  // Sign of the difference, corrected when the subtraction overflowed
  assign less    = sum[MSB] ^ add_ovf;
  assign equal   = ~|sum;

  always_comb begin
    cmp_bit = 1'b0;
    case (bonus_i)
      3'd0:    cmp_bit = less;
      3'd1:    cmp_bit = ~less & ~equal;
      3'd2:    cmp_bit = less | equal;
      3'd3:    cmp_bit = ~less;
      3'd4:    cmp_bit = ~equal;
      3'd6:    cmp_bit = equal;
      default: cmp_bit = 1'b0;
    endcase
  end

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res = l_and;
      OP_OR:   alu_res = l_or;
      OP_NOR:  alu_res = ~l_or;
      OP_NAND: alu_res = ~l_and;
      OP_ADD, OP_SUB: begin
        alu_res  = sum;
        alu_cout = carry[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_CMP:  alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // Optional multiplier
  // ---------------------------------------------------------------
  logic is_mul, last_step;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CNT_W-1:0]   cnt;

  assign is_mul    = (ctrl_i == OP_MUL);
  assign acc_nxt   = acc + (mplr[0] ? mcand : '0);
  // cnt counts completed steps; this edge performs step WIDTH
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (state == S_IDLE && start_i && is_mul) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, src1_i};
      mplr  <= src2_i;
      cnt   <= '0;
    end else if (state == S_MUL) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
    end
  end
`else
  assign is_mul    = 1'b0;
  assign last_step = 1'b1;
`endif

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = is_mul ? S_MUL : S_DONE;
      S_MUL:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == S_MUL);
    done_o = (state == S_DONE);
  end

  // ---------------------------------------------------------------
  // Result registers: written only on the edge that leads into DONE
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o   <= '0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (state == S_IDLE && start_i && !is_mul) begin
      result_o   <= alu_res;
      cout_o     <= alu_cout;
      overflow_o <= alu_ovf;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state == S_MUL && last_step) begin
      result_o   <= acc_nxt[WIDTH-1:0];
      cout_o     <= 1'b0;
      overflow_o <= |acc_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign zero_o = ~rst_i & ~|result_o;

endmodule
